// File: rtl/vga_game_pkg.sv
// Shared geometry, colour and mode definitions for the VGA game screen renderer.
package vga_game_pkg;

  localparam int H_VALID     = 640;
  localparam int V_VALID     = 480;
  localparam int UNIT_SIZE   = 30;
  localparam int PLAYER_X    = 200;
  localparam int PLAYER_SIZE = 40;
  localparam int NUM_OBS     = 10;
  localparam int NUM_TRAIL   = 41;
  localparam int TRAIL_SIZE  = 4;
  localparam int HEART_X0    = 10;
  localparam int HEART_Y0    = 10;
  localparam int HEART_SIZE  = 16;
  localparam int HEART_GAP   = 4;
  localparam int MAX_HEARTS  = 7;

  localparam int BAND_Y0  = 200;
  localparam int BAND_Y1  = 280;
  localparam int TITLE_X0 = 160;
  localparam int TITLE_X1 = 480;

  localparam logic [11:0] COL_BLACK   = 12'h000;
  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_HEART   = 12'h00F;
  localparam logic [11:0] COL_PLAYER  = 12'hF80;
  localparam logic [11:0] COL_CREEPER = 12'h0C0;
  localparam logic [11:0] COL_ZOMBIE  = 12'h6A2;
  localparam logic [11:0] COL_BG      = 12'hC84;
  localparam logic [11:0] COL_BAND    = 12'h00F;

  typedef enum logic [1:0] {
    GM_TITLE = 2'b00,
    GM_PLAY  = 2'b01,
    GM_PAUSE = 2'b10,
    GM_OVER  = 2'b11
  } gamemode_e;

  typedef enum logic [1:0] {
    OBS_BLACK   = 2'd0,
    OBS_WHITE   = 2'd1,
    OBS_CREEPER = 2'd2,
    OBS_ZOMBIE  = 2'd3
  } obs_class_e;

  function automatic logic [11:0] obs_colour(input logic [1:0] cls);
    case (obs_class_e'(cls))
      OBS_BLACK:   obs_colour = COL_BLACK;
      OBS_WHITE:   obs_colour = COL_WHITE;
      OBS_CREEPER: obs_colour = COL_CREEPER;
      default:     obs_colour = COL_ZOMBIE;
    endcase
  endfunction

endpackage

// File: rtl/vga_obstacle_layer.sv
// Parallel obstacle hit tests for the current pixel; the lowest-index hitting slot wins.
module vga_obstacle_layer
  import vga_game_pkg::*;
(
  input  logic [9:0] pix_x,
  input  logic [8:0] pix_y,
  input  logic [1:0] obstacle_class       [NUM_OBS],
  input  logic [9:0] obstacle_x_game_left [NUM_OBS],
  input  logic [2:0] width                [NUM_OBS],
  input  logic [8:0] obstacle_y_game_up   [NUM_OBS],
  input  logic [3:0] height               [NUM_OBS],
  output logic       hit,
  output logic [1:0] cls
);

  logic [NUM_OBS-1:0] slot_hit;

  // 11-bit extents so left + width*UNIT_SIZE cannot wrap.
  for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
    logic [10:0] x0, x1, y0, y1;
    assign x0 = {1'b0, obstacle_x_game_left[g]};
    assign y0 = {2'b0, obstacle_y_game_up[g]};
    assign x1 = x0 + 11'(width[g]) * 11'(UNIT_SIZE);
    assign y1 = y0 + 11'(height[g]) * 11'(UNIT_SIZE);
    assign slot_hit[g] = ({1'b0, pix_x} >= x0) && ({1'b0, pix_x} < x1) &&
                         ({2'b0, pix_y} >= y0) && ({2'b0, pix_y} < y1);
  end

  always_comb begin
    hit = 1'b0;
    cls = 2'd0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit = 1'b1;
        cls = obstacle_class[i];
      end
    end
  end

endmodule

// File: rtl/vga_screen_pic.sv
// Combinational pixel colour generator for the game screen, plus a frame counter for blinking.
module vga_screen_pic
  import vga_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [8:0] pix_y,
  input  logic [1:0] gamemode,
  input  logic [8:0] player_y,
  input  logic [2:0] heart,
  input  logic [1:0] obstacle_class       [NUM_OBS],
  input  logic [9:0] obstacle_x_game_left [NUM_OBS],
  input  logic [2:0] width                [NUM_OBS],
  input  logic [8:0] obstacle_y_game_up   [NUM_OBS],
  input  logic [3:0] height               [NUM_OBS],
  input  logic [9:0] trail_x              [NUM_TRAIL],
  input  logic [8:0] trail_y              [NUM_TRAIL],
  input  logic [3:0] trail_life           [NUM_TRAIL],
  output logic [11:0] rgb
);

  function automatic logic [11:0] dim(input logic [11:0] c);
    dim = {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

  logic [5:0]  frame_cnt;
  logic        frame_end;
  logic        blank;
  logic        obs_hit;
  logic [1:0]  obs_cls;
  logic        player_hit;
  logic [10:0] player_y1;
  logic [NUM_TRAIL-1:0] trail_hit;
  logic        trail_any;
  logic [3:0]  trail_lf;
  logic [MAX_HEARTS-1:0] heart_hit;
  logic        in_band;
  logic        in_title;
  logic [11:0] play_rgb;

  assign frame_end = (pix_x == 10'(H_VALID - 1)) && (pix_y == 9'(V_VALID - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 6'd1;
  end

  assign blank = (pix_x >= 10'(H_VALID)) || (pix_y >= 9'(V_VALID));

  vga_obstacle_layer u_obstacles (
    .pix_x                (pix_x),
    .pix_y                (pix_y),
    .obstacle_class       (obstacle_class),
    .obstacle_x_game_left (obstacle_x_game_left),
    .width                (width),
    .obstacle_y_game_up   (obstacle_y_game_up),
    .height               (height),
    .hit                  (obs_hit),
    .cls                  (obs_cls)
  );

  assign player_y1  = {2'b0, player_y} + 11'(PLAYER_SIZE);
  assign player_hit = (pix_x >= 10'(PLAYER_X)) && (pix_x < 10'(PLAYER_X + PLAYER_SIZE)) &&
                      ({2'b0, pix_y} >= {2'b0, player_y}) && ({2'b0, pix_y} < player_y1);

  for (genvar g = 0; g < NUM_TRAIL; g++) begin : g_trail
    logic [10:0] x1, y1;
    assign x1 = {1'b0, trail_x[g]} + 11'(TRAIL_SIZE);
    assign y1 = {2'b0, trail_y[g]} + 11'(TRAIL_SIZE);
    assign trail_hit[g] = (trail_life[g] != 4'd0) &&
                          (pix_x >= trail_x[g]) && ({1'b0, pix_x} < x1) &&
                          (pix_y >= trail_y[g]) && ({2'b0, pix_y} < y1);
  end

  always_comb begin
    trail_any = 1'b0;
    trail_lf  = 4'd0;
    for (int i = NUM_TRAIL - 1; i >= 0; i--) begin
      if (trail_hit[i]) begin
        trail_any = 1'b1;
        trail_lf  = trail_life[i];
      end
    end
  end

  for (genvar g = 0; g < MAX_HEARTS; g++) begin : g_heart
    localparam int HX = HEART_X0 + g * (HEART_SIZE + HEART_GAP);
    assign heart_hit[g] = (3'(g) < heart) &&
                          (pix_x >= 10'(HX)) && (pix_x < 10'(HX + HEART_SIZE)) &&
                          (pix_y >= 9'(HEART_Y0)) && (pix_y < 9'(HEART_Y0 + HEART_SIZE));
  end

  assign in_band  = (pix_y >= 9'(BAND_Y0)) && (pix_y < 9'(BAND_Y1));
  assign in_title = in_band && (pix_x >= 10'(TITLE_X0)) && (pix_x < 10'(TITLE_X1));

  always_comb begin
    play_rgb = COL_BG;
    if (|heart_hit)     play_rgb = COL_HEART;
    else if (player_hit) play_rgb = COL_PLAYER;
    else if (trail_any)  play_rgb = {4'h0, 1'b0, trail_lf[3:1], trail_lf};
    else if (obs_hit)    play_rgb = obs_colour(obs_cls);
  end

  always_comb begin
    rgb = COL_BLACK;
    if (rst_n && !blank) begin
      case (gamemode_e'(gamemode))
        GM_TITLE: rgb = in_title ? COL_WHITE : COL_BG;
        GM_PLAY:  rgb = play_rgb;
        GM_PAUSE: rgb = dim(play_rgb);
        default:  rgb = (in_band && !frame_cnt[5]) ? COL_BAND : play_rgb;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_screen_pic.sv
// Scenario bench for vga_screen_pic: directed cases plus randomized scenes against a reference model.
module tb_vga_screen_pic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [1:0]  gamemode;
  logic [8:0]  player_y;
  logic [2:0]  heart;
  logic [1:0]  obstacle_class       [10];
  logic [9:0]  obstacle_x_game_left [10];
  logic [2:0]  width                [10];
  logic [8:0]  obstacle_y_game_up   [10];
  logic [3:0]  height               [10];
  logic [9:0]  trail_x              [41];
  logic [8:0]  trail_y              [41];
  logic [3:0]  trail_life           [41];
  logic [11:0] rgb;

  int n_checks = 0;
  int n_fail   = 0;
  int model_fc;

  vga_screen_pic dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pix_x                (pix_x),
    .pix_y                (pix_y),
    .gamemode             (gamemode),
    .player_y             (player_y),
    .heart                (heart),
    .obstacle_class       (obstacle_class),
    .obstacle_x_game_left (obstacle_x_game_left),
    .width                (width),
    .obstacle_y_game_up   (obstacle_y_game_up),
    .height               (height),
    .trail_x              (trail_x),
    .trail_y              (trail_y),
    .trail_life           (trail_life),
    .rgb                  (rgb)
  );

  always #5 clk = ~clk;

  // Frame counter as described: counts end-of-frame positions seen on clock edges, mod 64.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_fc <= 0;
    else if (pix_x == 10'd639 && pix_y == 9'd479) model_fc <= (model_fc + 1) % 64;
  end

  function automatic logic [11:0] ref_rgb(int x, int y, int mode, int fc);
    int c, dx, life;
    if (x >= 640 || y >= 480) return 12'h000;
    if (mode == 0) return (y >= 200 && y < 280 && x >= 160 && x < 480) ? 12'hFFF : 12'hC84;
    c = 'hC84;
    for (int i = 0; i < 10; i++) begin
      if (x >= int'(obstacle_x_game_left[i]) && x < int'(obstacle_x_game_left[i]) + int'(width[i]) * 30 &&
          y >= int'(obstacle_y_game_up[i]) && y < int'(obstacle_y_game_up[i]) + int'(height[i]) * 30) begin
        case (obstacle_class[i])
          2'd0: c = 'h000;
          2'd1: c = 'hFFF;
          2'd2: c = 'h0C0;
          default: c = 'h6A2;
        endcase
        break;
      end
    end
    for (int k = 0; k < 41; k++) begin
      life = int'(trail_life[k]);
      if (life != 0 && x - int'(trail_x[k]) >= 0 && x - int'(trail_x[k]) < 4 &&
          y - int'(trail_y[k]) >= 0 && y - int'(trail_y[k]) < 4) begin
        c = (life / 2) * 16 + life;
        break;
      end
    end
    if (x >= 200 && x < 240 && y >= int'(player_y) && y < int'(player_y) + 40) c = 'hF80;
    dx = x - 10;
    if (dx >= 0 && dx / 20 < int'(heart) && dx % 20 < 16 && y >= 10 && y < 26) c = 'h00F;
    if (mode == 2) c = ((c / 256) / 2) * 256 + (((c / 16) % 16) / 2) * 16 + (c % 16) / 2;
    if (mode == 3 && y >= 200 && y < 280 && fc < 32) c = 'h00F;
    return 12'(c);
  endfunction

  task automatic clear_scene();
    for (int i = 0; i < 10; i++) begin
      obstacle_class[i] = 2'd0; obstacle_x_game_left[i] = 10'd0; width[i] = 3'd0;
      obstacle_y_game_up[i] = 9'd0; height[i] = 4'd0;
    end
    for (int k = 0; k < 41; k++) begin
      trail_x[k] = 10'd0; trail_y[k] = 9'd0; trail_life[k] = 4'd0;
    end
    player_y = 9'd0;
    heart    = 3'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; gamemode = 2'b01; pix_x = 10'd300; pix_y = 9'd300; player_y = 9'd280;
    #1;
    n_checks++;
    if (rgb !== 12'h000) begin
      n_fail++; $display("FAIL reset_rgb got=%h exp=000", rgb);
    end
    @(negedge clk);
    rst_n = 1'b1; pix_x = 10'd700; pix_y = 9'd10;
    #1;
    n_checks++;
    if (rgb !== 12'h000) begin
      n_fail++; $display("FAIL hblank got=%h exp=000", rgb);
    end
    @(negedge clk);
    pix_x = 10'd10; pix_y = 9'd480;
    #1;
    n_checks++;
    if (rgb !== 12'h000) begin
      n_fail++; $display("FAIL vblank got=%h exp=000", rgb);
    end
  endtask

  task automatic test_player();
    logic [9:0]  xs [3] = '{10'd200, 10'd239, 10'd240};
    logic [8:0]  ys [3] = '{9'd200, 9'd239, 9'd200};
    logic [11:0] ex [3] = '{12'hF80, 12'hF80, 12'hC84};
    clear_scene();
    gamemode = 2'b01; player_y = 9'd200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pix_x = xs[i]; pix_y = ys[i];
      #1;
      n_checks++;
      if (rgb !== ex[i]) begin
        n_fail++; $display("FAIL player(%0d,%0d) got=%h exp=%h", xs[i], ys[i], rgb, ex[i]);
      end
    end
  endtask

  task automatic test_obstacles();
    @(negedge clk);
    obstacle_class[0] = 2'd2; obstacle_x_game_left[0] = 10'd100; obstacle_y_game_up[0] = 9'd100;
    width[0] = 3'd2; height[0] = 4'd1;
    pix_x = 10'd159; pix_y = 9'd129;
    #1;
    n_checks++;
    if (rgb !== 12'h0C0) begin
      n_fail++; $display("FAIL obs_inside got=%h exp=0C0", rgb);
    end
    @(negedge clk);
    pix_x = 10'd160;
    #1;
    n_checks++;
    if (rgb !== 12'hC84) begin
      n_fail++; $display("FAIL obs_right_edge got=%h exp=C84", rgb);
    end
    @(negedge clk);
    pix_x = 10'd130; pix_y = 9'd130;
    #1;
    n_checks++;
    if (rgb !== 12'hC84) begin
      n_fail++; $display("FAIL obs_bottom_edge got=%h exp=C84", rgb);
    end
    @(negedge clk);
    obstacle_class[1] = 2'd1; obstacle_x_game_left[1] = 10'd100; obstacle_y_game_up[1] = 9'd100;
    width[1] = 3'd2; height[1] = 4'd1;
    pix_x = 10'd120; pix_y = 9'd110;
    #1;
    n_checks++;
    if (rgb !== 12'h0C0) begin
      n_fail++; $display("FAIL obs_priority got=%h exp=0C0", rgb);
    end
  endtask

  task automatic test_trail();
    @(negedge clk);
    trail_x[3] = 10'd195; trail_y[3] = 9'd210; trail_life[3] = 4'd10;
    pix_x = 10'd196; pix_y = 9'd211;
    #1;
    n_checks++;
    if (rgb !== 12'h05A) begin
      n_fail++; $display("FAIL trail_live got=%h exp=05A", rgb);
    end
    @(negedge clk);
    trail_x[7] = 10'd196; trail_y[7] = 9'd211; trail_life[7] = 4'd3;
    #1;
    n_checks++;
    if (rgb !== 12'h05A) begin
      n_fail++; $display("FAIL trail_priority got=%h exp=05A", rgb);
    end
    @(negedge clk);
    trail_life[3] = 4'd0; trail_life[7] = 4'd0;
    #1;
    n_checks++;
    if (rgb !== 12'hC84) begin
      n_fail++; $display("FAIL trail_dead got=%h exp=C84", rgb);
    end
  endtask

  task automatic test_hud_pause();
    logic [9:0]  xs [5] = '{10'd50, 10'd70, 10'd26, 10'd145, 10'd150};
    logic [8:0]  ys [5] = '{9'd12, 9'd12, 9'd10, 9'd25, 9'd25};
    logic [2:0]  hs [5] = '{3'd3, 3'd3, 3'd7, 3'd7, 3'd7};
    logic [11:0] ex [5] = '{12'h00F, 12'hC84, 12'hC84, 12'h00F, 12'hC84};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      heart = hs[i]; pix_x = xs[i]; pix_y = ys[i];
      #1;
      n_checks++;
      if (rgb !== ex[i]) begin
        n_fail++; $display("FAIL heart(%0d,%0d,h=%0d) got=%h exp=%h", xs[i], ys[i], hs[i], rgb, ex[i]);
      end
    end
    @(negedge clk);
    heart = 3'd3; gamemode = 2'b10; pix_x = 10'd70; pix_y = 9'd12;
    #1;
    n_checks++;
    if (rgb !== 12'h642) begin
      n_fail++; $display("FAIL pause_bg got=%h exp=642", rgb);
    end
    @(negedge clk);
    pix_x = 10'd210; pix_y = 9'd0; player_y = 9'd0;
    #1;
    n_checks++;
    if (rgb !== 12'h740) begin
      n_fail++; $display("FAIL pause_player got=%h exp=740", rgb);
    end
  endtask

  task automatic test_gameover();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; gamemode = 2'b11; player_y = 9'd300; pix_x = 10'd5; pix_y = 9'd240;
    #1;
    n_checks++;
    if (rgb !== 12'h00F) begin
      n_fail++; $display("FAIL over_band_on got=%h exp=00F", rgb);
    end
    @(negedge clk);
    pix_y = 9'd199;
    #1;
    n_checks++;
    if (rgb !== 12'hC84) begin
      n_fail++; $display("FAIL over_band_top got=%h exp=C84", rgb);
    end
    @(negedge clk);
    pix_x = 10'd639; pix_y = 9'd479;
    repeat (31) @(posedge clk);
    @(negedge clk);
    pix_x = 10'd5; pix_y = 9'd279;
    #1;
    n_checks++;
    if (rgb !== 12'h00F) begin
      n_fail++; $display("FAIL over_after31 got=%h exp=00F", rgb);
    end
    @(negedge clk);
    pix_x = 10'd639; pix_y = 9'd479;
    @(posedge clk);
    @(negedge clk);
    pix_x = 10'd5; pix_y = 9'd240;
    #1;
    n_checks++;
    if (rgb !== 12'hC84) begin
      n_fail++; $display("FAIL over_after32 got=%h exp=C84", rgb);
    end
  endtask

  task automatic test_title();
    logic [9:0]  xs [4] = '{10'd300, 10'd200, 10'd159, 10'd479};
    logic [8:0]  ys [4] = '{9'd220, 9'd200, 9'd220, 9'd279};
    logic [11:0] ex [4] = '{12'hFFF, 12'hFFF, 12'hC84, 12'hFFF};
    gamemode = 2'b00; player_y = 9'd200; heart = 3'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pix_x = xs[i]; pix_y = ys[i];
      #1;
      n_checks++;
      if (rgb !== ex[i]) begin
        n_fail++; $display("FAIL title(%0d,%0d) got=%h exp=%h", xs[i], ys[i], rgb, ex[i]);
      end
    end
    @(negedge clk);
    pix_x = 10'd210; pix_y = 9'd190;
    #1;
    n_checks++;
    if (rgb !== 12'hC84) begin
      n_fail++; $display("FAIL title_no_player got=%h exp=C84", rgb);
    end
  endtask

  task automatic test_random();
    logic [11:0] exp_c;
    int sel, s;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        obstacle_class[i]       = 2'($urandom_range(0, 3));
        obstacle_x_game_left[i] = 10'($urandom_range(0, 639));
        obstacle_y_game_up[i]   = 9'($urandom_range(0, 479));
        width[i]                = 3'($urandom_range(0, 7));
        height[i]               = 4'($urandom_range(0, 15));
      end
      for (int k = 0; k < 41; k++) begin
        trail_x[k]    = 10'($urandom_range(0, 639));
        trail_y[k]    = 9'($urandom_range(0, 479));
        trail_life[k] = 4'($urandom_range(0, 15));
      end
      player_y = 9'($urandom_range(0, 479));
      heart    = 3'($urandom_range(0, 7));
      gamemode = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        s = $urandom_range(0, 40);
        pix_x = trail_x[s] + 10'($urandom_range(0, 4));
        pix_y = trail_y[s] + 9'($urandom_range(0, 4));
      end else if (sel == 1) begin
        pix_x = 10'($urandom_range(0, 45));
        pix_y = 9'($urandom_range(5, 30));
      end else begin
        pix_x = 10'($urandom_range(0, 700));
        pix_y = 9'($urandom_range(0, 511));
      end
      #1;
      exp_c = ref_rgb(int'(pix_x), int'(pix_y), int'(gamemode), model_fc);
      n_checks++;
      if (rgb !== exp_c) begin
        n_fail++;
        $display("FAIL random(%0d,%0d,mode=%0d) got=%h exp=%h", pix_x, pix_y, gamemode, rgb, exp_c);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pix_x = 10'd0; pix_y = 9'd0; gamemode = 2'b00;
    clear_scene();
    test_reset();
    test_player();
    test_obstacles();
    test_trail();
    test_hud_pause();
    test_gameover();
    test_title();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
